// File: rtl/bird_pkg.sv
// Shared definitions for the flappy-bird controller: state encodings and
// default physics constants, so draw/score logic decodes the same values.
package bird_pkg;

  typedef enum logic [2:0] {
    ST_READY   = 3'd0,
    ST_START   = 3'd1,
    ST_RISING  = 3'd2,
    ST_FALLING = 3'd3,
    ST_STOP    = 3'd4
  } bird_state_e;

  localparam int DEF_Y_W         = 7;
  localparam int DEF_Y_MAX       = 119;
  localparam int DEF_BIRD_H      = 4;
  localparam int DEF_Y_START     = 60;
  localparam int DEF_V_W         = 5;
  localparam int DEF_FLAP_V      = -6;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_V_MAX       = 7;
  localparam int DEF_HOLD_FRAMES = 60;

  // True for the states in which the bird is in play.
  function automatic logic is_alive(input bird_state_e s);
    return (s == ST_START) || (s == ST_RISING) || (s == ST_FALLING);
  endfunction

endpackage

// File: rtl/bird_motion_ctrl_if.sv
// Bundle between the game side (key sync, collision detector, draw logic)
// and the bird controller.
// Handshake: frame_tick is a one-cycle strobe with no back-pressure; every
// output is a registered level, valid in every cycle, except game_over which
// is a one-cycle pulse.
interface bird_motion_ctrl_if #(
  parameter int Y_W = bird_pkg::DEF_Y_W,
  parameter int V_W = bird_pkg::DEF_V_W
) ();
  logic                  frame_tick;
  logic                  flap_key;
  logic                  collide;
  logic [Y_W-1:0]        bird_y;
  logic signed [V_W-1:0] bird_v;
  logic [2:0]            state;
  logic                  alive;
  logic                  game_over;

  modport master (
    output frame_tick, flap_key, collide,
    input  bird_y, bird_v, state, alive, game_over
  );

  modport slave (
    input  frame_tick, flap_key, collide,
    output bird_y, bird_v, state, alive, game_over
  );
endinterface

// File: rtl/bird_motion_ctrl_flap_edge_detect.sv
// Rising-edge detector on the (already synchronised) flap key, so a held
// key produces a single flap.
module flap_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic flap_key,
  output logic flap_edge
);
  logic flap_q;

  // Remember last cycle's key level.
  always_ff @(posedge clk) begin
    if (reset) flap_q <= 1'b0;
    else       flap_q <= flap_key;
  end

  assign flap_edge = flap_key & ~flap_q;
endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird state machine with vertical physics: gravity, flap impulse, terminal
// velocity, ceiling clamp, floor detection and a timed game-over hold.
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int Y_W         = DEF_Y_W,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int BIRD_H      = DEF_BIRD_H,
  parameter int Y_START     = DEF_Y_START,
  parameter int V_W         = DEF_V_W,
  parameter int FLAP_V      = DEF_FLAP_V,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int V_MAX       = DEF_V_MAX,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic             clk,
  input  logic             reset,
  bird_motion_ctrl_if.slave bus
);
  localparam int YE_W   = Y_W + 2;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [Y_W-1:0]         Y_START_C  = Y_W'(Y_START);
  localparam logic [Y_W-1:0]         Y_LAUNCH_C = Y_W'(Y_START + FLAP_V);
  localparam logic [Y_W-1:0]         FLOOR_C    = Y_W'(Y_MAX - BIRD_H + 1);
  localparam logic signed [YE_W-1:0] FLOOR_E    = YE_W'(Y_MAX - BIRD_H + 1);
  localparam logic signed [V_W-1:0]  FLAP_V_C   = V_W'(FLAP_V);
  localparam logic signed [V_W-1:0]  V_MAX_C    = V_W'(V_MAX);
  localparam logic signed [V_W:0]    V_MAX_E    = (V_W+1)'(V_MAX);
  localparam logic signed [V_W:0]    GRAV_C     = (V_W+1)'(GRAVITY);
  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

  bird_state_e           state_q, state_n;
  logic [Y_W-1:0]        y_q, y_n;
  logic signed [V_W-1:0] v_q, v_n;
  logic [HOLD_W-1:0]     hold_q, hold_n;
  logic                  pend_q, pend_n;
  logic                  alive_q, over_q, over_n;

  logic                  flap_edge;
  logic                  flap_now;
  logic signed [V_W:0]   v_sum;
  logic signed [V_W-1:0] v_grav, v_new;
  logic signed [YE_W-1:0] y_new;

  flap_edge_detect u_flap (
    .clk       (clk),
    .reset     (reset),
    .flap_key  (bus.flap_key),
    .flap_edge (flap_edge)
  );

  // State, physics and hold-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_READY;
      y_q     <= Y_START_C;
      v_q     <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      alive_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      y_q     <= y_n;
      v_q     <= v_n;
      hold_q  <= hold_n;
      pend_q  <= pend_n;
      alive_q <= is_alive(state_n);
      over_q  <= over_n;
    end
  end

  // Next-state and physics update; a flap edge coincident with the tick
  // counts for that tick, collide wins over any tick in flight.
  always_comb begin
    state_n  = state_q;
    y_n      = y_q;
    v_n      = v_q;
    hold_n   = hold_q;
    pend_n   = pend_q;
    over_n   = 1'b0;
    flap_now = pend_q | flap_edge;
    v_sum    = (V_W+1)'(v_q) + GRAV_C;
    v_grav   = (v_sum > V_MAX_E) ? V_MAX_C : v_sum[V_W-1:0];
    v_new    = flap_now ? FLAP_V_C : v_grav;
    y_new    = $signed({2'b00, y_q}) + YE_W'(v_new);

    case (state_q)
      ST_READY: begin
        y_n    = Y_START_C;
        v_n    = '0;
        pend_n = 1'b0;
        hold_n = '0;
        if (flap_edge) state_n = ST_START;
      end
      ST_START: begin
        if (flap_edge) pend_n = 1'b1;
        if (bus.frame_tick) begin
          pend_n  = 1'b0;
          v_n     = FLAP_V_C;
          y_n     = Y_LAUNCH_C;
          state_n = ST_RISING;
        end
      end
      ST_RISING, ST_FALLING: begin
        if (flap_edge) pend_n = 1'b1;
        if (bus.collide) begin
          state_n = ST_STOP;
          over_n  = 1'b1;
          hold_n  = '0;
          pend_n  = 1'b0;
        end else if (bus.frame_tick) begin
          pend_n = 1'b0;
          if (y_new[YE_W-1]) begin
            // Hitting the ceiling only stops the climb.
            y_n     = '0;
            v_n     = '0;
            state_n = ST_FALLING;
          end else if (y_new > FLOOR_E) begin
            y_n     = FLOOR_C;
            state_n = ST_STOP;
            over_n  = 1'b1;
            hold_n  = '0;
          end else begin
            y_n     = y_new[Y_W-1:0];
            v_n     = v_new;
            state_n = v_new[V_W-1] ? ST_RISING : ST_FALLING;
          end
        end
      end
      ST_STOP: begin
        pend_n = 1'b0;
        if (bus.frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            state_n = ST_READY;
            y_n     = Y_START_C;
            v_n     = '0;
            hold_n  = '0;
          end else begin
            hold_n = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_READY;
        y_n     = Y_START_C;
        v_n     = '0;
        hold_n  = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

  assign bus.bird_y    = y_q;
  assign bus.bird_v    = v_q;
  assign bus.state     = state_q;
  assign bus.alive     = alive_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl: stimulus steps push expected output
// snapshots; a negedge monitor pops and compares them on the due cycle.
module tb_bird_motion_ctrl;
  import bird_pkg::*;

  localparam int W = 17;  // {state[3], y[7], v[5], alive, game_over}

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  string        name_q[$];

  bird_motion_ctrl_if bus ();

  bird_motion_ctrl dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Clock, cycle counter and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ex(input bird_state_e s, input int y,
                                      input int v, input logic al,
                                      input logic go);
    logic [6:0] yy;
    logic [4:0] vv;
    yy = 7'(y);
    vv = 5'(v);
    return {s, yy, vv, al, go};
  endfunction

  // One clock of stimulus; optionally queue the snapshot due after it.
  task automatic step(input logic r, input logic t, input logic f,
                      input logic c, input logic chk,
                      input logic [W-1:0] e, input string nm);
    @(posedge clk);
    #1;
    rst            = r;
    bus.frame_tick = t;
    bus.flap_key   = f;
    bus.collide    = c;
    if (chk) begin
      exp_q.push_back(e);
      stamp_q.push_back(cyc + 1);
      name_q.push_back(nm);
    end
  endtask

  // Monitor: compare every snapshot due in this cycle.
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    string nm;
    while (stamp_q.size() > 0 && stamp_q[0] == cyc) begin
      void'(stamp_q.pop_front());
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {bus.state, bus.bird_y, bus.bird_v, bus.alive, bus.game_over};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got st=%0d y=%0d v=%0d al=%0b go=%0b, expected st=%0d y=%0d v=%0d al=%0b go=%0b",
                 nm, got[16:14], got[13:7], $signed(got[6:2]), got[1], got[0],
                 want[16:14], want[13:7], $signed(want[6:2]), want[1], want[0]);
      end
    end
  end

  int ty[21] = '{49, 45, 42, 40, 39, 39, 40, 42, 45, 49, 54,
                 60, 67, 74, 81, 88, 95, 102, 109, 116, 116};
  int tv[21] = '{-5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5,
                 6, 7, 7, 7, 7, 7, 7, 7, 7, 7};

  initial begin
    logic [W-1:0] e;
    logic key;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.flap_key   = 1'b0;
    bus.collide    = 1'b0;

    // Reset and launch.
    step(1, 0, 0, 0, 0, '0, "");
    step(1, 0, 0, 0, 1, ex(ST_READY, 60, 0, 0, 0), "reset");
    step(0, 0, 0, 0, 1, ex(ST_READY, 60, 0, 0, 0), "ready_idle");
    step(0, 0, 1, 0, 1, ex(ST_START, 60, 0, 1, 0), "flap_start");
    step(0, 1, 1, 0, 1, ex(ST_RISING, 54, -6, 1, 0), "launch");

    // Key held for the first frames: one impulse only, then free fall to floor.
    for (int i = 1; i <= 21; i++) begin
      key = (i <= 9);
      if (i <= 5)       e = ex(ST_RISING, ty[i-1], tv[i-1], 1, 0);
      else if (i <= 20) e = ex(ST_FALLING, ty[i-1], tv[i-1], 1, 0);
      else              e = ex(ST_STOP, 116, 7, 0, 1);
      step(0, 1, key, 0, 1, e, $sformatf("fall_tick%0d", i));
      if (i == 21) e = ex(ST_STOP, 116, 7, 0, 0);
      step(0, 0, key, 0, 1, e, $sformatf("fall_hold%0d", i));
    end

    // Hold in STOP for 60 ticks; key and collide are ignored.
    for (int i = 1; i <= 60; i++) begin
      if (i < 60) e = ex(ST_STOP, 116, 7, 0, 0);
      else        e = ex(ST_READY, 60, 0, 0, 0);
      step(0, 1, i[0], 1, 1, e, $sformatf("stop_tick%0d", i));
    end
    step(0, 0, 0, 0, 1, ex(ST_READY, 60, 0, 0, 0), "ready_again");

    // Flaps coincident with ticks drive the bird into the ceiling.
    step(0, 0, 1, 0, 1, ex(ST_START, 60, 0, 1, 0), "ceil_start");
    step(0, 1, 0, 0, 1, ex(ST_RISING, 54, -6, 1, 0), "ceil_launch");
    for (int j = 1; j <= 10; j++) begin
      if (j <= 9) e = ex(ST_RISING, 54 - 6 * j, -6, 1, 0);
      else        e = ex(ST_FALLING, 0, 0, 1, 0);
      step(0, 1, 1, 0, 1, e, $sformatf("ceil_tick%0d", j));
      step(0, 0, 0, 0, 1, e, $sformatf("ceil_hold%0d", j));
    end
    step(0, 1, 0, 0, 1, ex(ST_FALLING, 1, 1, 1, 0), "after_ceil");

    // Collide between ticks, frozen in STOP, then reset out of STOP.
    step(0, 0, 0, 1, 1, ex(ST_STOP, 1, 1, 0, 1), "collide");
    step(0, 0, 0, 0, 1, ex(ST_STOP, 1, 1, 0, 0), "collide_pulse_end");
    step(0, 1, 1, 0, 1, ex(ST_STOP, 1, 1, 0, 0), "stop_frozen");
    step(1, 0, 0, 0, 1, ex(ST_READY, 60, 0, 0, 0), "reset_in_stop");
    step(0, 0, 0, 0, 1, ex(ST_READY, 60, 0, 0, 0), "ready_after_reset");

    // A mid-frame flap is held pending until the next tick, used once.
    step(0, 0, 1, 0, 1, ex(ST_START, 60, 0, 1, 0), "pend_start");
    step(0, 1, 0, 0, 1, ex(ST_RISING, 54, -6, 1, 0), "pend_launch");
    step(0, 0, 1, 0, 1, ex(ST_RISING, 54, -6, 1, 0), "pend_flap");
    step(0, 0, 0, 0, 1, ex(ST_RISING, 54, -6, 1, 0), "pend_wait");
    step(0, 1, 0, 0, 1, ex(ST_RISING, 48, -6, 1, 0), "pend_apply");
    step(0, 1, 0, 0, 1, ex(ST_RISING, 43, -5, 1, 0), "pend_consumed");

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      $display("FAIL drain: %0d expected snapshots never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
